operand_stage: RTL

- Issue stage directly upstream of the 8-bit ALU top.
- Accepts 12-bit two-address instructions over a valid/ready handshake and reads an 8x8 register file.
- Drives registered operands, opcode and s_or_c into the ALU, then writes the ALU's registered result back to the destination register.
- Tracks in-flight destinations and stalls read-after-write hazards.

---
 rtl/operand_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/operand_stage.sv
// operand_stage: issue stage in front of the 8-bit ALU.
//
// Accepts 12-bit two-address instructions over a valid/ready handshake,
// reads operands from an 8x8 register file, and registers opcode and
// operands into the ALU. The ALU's registered result is written back to the
// destination register two edges after issue. A two-stage pending pipe
// tracks in-flight destinations: a hit on P1 stalls issue, and a hit on P2
// is served by write-through from alu_result.
//
// Ports:
//   clk, reset        - clock; synchronous active-low reset
//   instr             - [11:8] opcode, [7] s_or_c, [6:4] rd/rs1, [3:1] rs2,
//                       [0] ignored
//   instr_valid/ready - issue handshake
//   alu_in1/in2       - registered operands to the ALU
//   alu_opcode        - registered opcode (NOP_OPCODE when idle)
//   alu_s_or_c        - registered s_or_c
//   alu_result        - ALU registered result, written back
//   ld_en/addr/data   - host register load; ld_ready when accepted
//   dbg_addr/dbg_data - combinational debug read with write-through
//   busy              - a writeback is pending
//   stall_cnt         - saturating stall counter, present only when
//                       OPERAND_STAGE_STALL_CNT_EN is defined
module operand_stage #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned NUM_REGS   = 8,
   parameter logic [3:0]  NOP_OPCODE = 4'hF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [11:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [3:0]        alu_opcode,
   output logic              alu_s_or_c,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              ld_en,
   input  logic [2:0]        ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              busy
`ifdef OPERAND_STAGE_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic       p1_valid_q, p2_valid_q;
   logic [2:0] p1_rd_q, p2_rd_q;

   logic [3:0]  opcode;
   logic        s_or_c;
   logic [2:0]  rs1, rs2;
   logic        unused_instr_bit;

   logic [DATA_W-1:0] rs1_data, rs2_data;
   logic              accept, ld_fire, hazard;

   assign opcode           = instr[11:8];
   assign s_or_c           = instr[7];
   assign rs1              = instr[6:4];
   assign rs2              = instr[3:1];
   assign unused_instr_bit = instr[0];

   // Reads bypass the array when the register is about to be written at the
   // next edge, so a P2 match never needs a stall.
   always_comb begin
      rs1_data = regs_q[rs1];
      rs2_data = regs_q[rs2];
      dbg_data = regs_q[dbg_addr];
      if (p2_valid_q && (rs1 == p2_rd_q))      rs1_data = alu_result;
      if (p2_valid_q && (rs2 == p2_rd_q))      rs2_data = alu_result;
      if (p2_valid_q && (dbg_addr == p2_rd_q)) dbg_data = alu_result;
   end

   // P1's result is not yet on alu_result, so a P1 match must wait a cycle.
   assign hazard      = p1_valid_q && ((rs1 == p1_rd_q) || (rs2 == p1_rd_q));
   assign instr_ready = reset && !hazard;
   assign accept      = instr_valid && instr_ready;
   assign busy        = p1_valid_q || p2_valid_q;

   // Issue has priority; a load only goes in with the pipe empty, so it can
   // never collide with a writeback.
   assign ld_ready = reset && !busy && !accept;
   assign ld_fire  = ld_en && ld_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_opcode <= '0;
         alu_s_or_c <= 1'b0;
         p1_valid_q <= 1'b0;
         p1_rd_q    <= '0;
         p2_valid_q <= 1'b0;
         p2_rd_q    <= '0;
      end else begin
         if (accept) begin
            alu_in1    <= rs1_data;
            alu_in2    <= rs2_data;
            alu_opcode <= opcode;
            alu_s_or_c <= s_or_c;
            p1_valid_q <= (opcode != NOP_OPCODE);
            p1_rd_q    <= rs1;
         end else begin
            // Operands hold; NOP keeps the ALU recomputing harmlessly.
            alu_opcode <= NOP_OPCODE;
            p1_valid_q <= 1'b0;
            p1_rd_q    <= '0;
         end
         p2_valid_q <= p1_valid_q;
         p2_rd_q    <= p1_rd_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         if (p2_valid_q) regs_q[p2_rd_q] <= alu_result;
         if (ld_fire)    regs_q[ld_addr] <= ld_data;
      end
   end

`ifdef OPERAND_STAGE_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else if (instr_valid && !instr_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
